// File: rtl/demux_drive_seq_if.sv
// Handshake and demux-drive bundle between a word producer and demux_drive_seq.
// state_dbg exposes the sequencer FSM state for checkers.
interface demux_drive_seq_if #(
    parameter int DWIDTH = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] in_data;
    logic              s0;
    logic              s1;
    logic              s2;
    logic              i;
    logic              busy;
    logic              done;
    logic [1:0]        state_dbg;

    modport master (
        output in_valid, in_data,
        input  in_ready, s0, s1, s2, i, busy, done, state_dbg
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, s0, s1, s2, i, busy, done, state_dbg
    );
endinterface

// File: rtl/demux_drive_seq.sv
// Sequencer feeding a 1-to-8 demux: accepts a word, then drives select/data one channel per clock.
// Optional back-to-back mode: define DEMUX_SEQ_B2B_EN.
module demux_drive_seq #(
    parameter int DWIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    demux_drive_seq_if.slave bus
);
    // valid/ready: a word transfers on any rising edge where in_valid && in_ready;
    // in_data is sampled only on that edge and in_valid may be held without effect otherwise.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        sel_q, sel_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              i_q, i_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready;
    logic              hs;
    logic              last_ch;
`ifdef DEMUX_SEQ_B2B_EN
    logic              pend_q, pend_d;
`endif

    assign last_ch = (cnt_q == 3'd7);
`ifdef DEMUX_SEQ_B2B_EN
    assign ready = (state_q == IDLE) || ((state_q == SHIFT) && last_ch);
`else
    assign ready = (state_q == IDLE);
`endif
    assign hs = bus.in_valid && ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        sel_d   = 3'd0;
        i_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef DEMUX_SEQ_B2B_EN
        pend_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (hs) begin
                    data_d  = bus.in_data;
                    cnt_d   = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Select and data are registered together so each channel sees a stable select.
                sel_d  = cnt_q;
                i_d    = data_q[cnt_q];
                busy_d = 1'b1;
                cnt_d  = cnt_q + 3'd1;
                if (last_ch) begin
                    state_d = DONE;
`ifdef DEMUX_SEQ_B2B_EN
                    if (hs) begin
                        data_d  = bus.in_data;
                        state_d = SHIFT;
                        pend_d  = 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef DEMUX_SEQ_B2B_EN
        // Chained word: the finished word's done lands alongside channel 0 of the next.
        if (pend_q) done_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            data_q  <= '0;
            sel_q   <= 3'd0;
            i_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DEMUX_SEQ_B2B_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DEMUX_SEQ_B2B_EN
            pend_q  <= pend_d;
`endif
        end
    end

    assign bus.in_ready  = ready;
    assign bus.s0        = sel_q[2];
    assign bus.s1        = sel_q[1];
    assign bus.s2        = sel_q[0];
    assign bus.i         = i_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;
endmodule
